// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: opcode map, sequencer state
// encoding, instruction-class decode and per-class final execute state.
package cpu_pkg;

  localparam int OPW = 5;                       // opcode width, opcode = ir[31:27]
  localparam logic [4:0] ADD_OP = 5'b00011;     // ALU code for address/branch sums

  // Opcode map
  localparam logic [OPW-1:0] OP_LD      = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI     = 5'b00001;
  localparam logic [OPW-1:0] OP_ST      = 5'b00010;
  localparam logic [OPW-1:0] OP_ALU_R_LO = 5'b00011;  // add .. first R-type
  localparam logic [OPW-1:0] OP_ALU_R_HI = 5'b01011;  // last R-type
  localparam logic [OPW-1:0] OP_ADDI    = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI     = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL     = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV     = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG     = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT     = 5'b10010;
  localparam logic [OPW-1:0] OP_BRX     = 5'b10011;
  localparam logic [OPW-1:0] OP_JR      = 5'b10100;
  localparam logic [OPW-1:0] OP_JAL     = 5'b10101;
  localparam logic [OPW-1:0] OP_IN      = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT     = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI    = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO    = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP     = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT    = 5'b11011;

  // Sequencer state encoding (T0..T7 are consecutive so execute can step by +1)
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST,
    CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP,
    CLS_HALT
  } cls_t;

  // Undefined opcodes fall into CLS_NOP.
  function automatic cls_t decode_class(input logic [OPW-1:0] op);
    cls_t c;
    if (op == OP_LD)                                c = CLS_LD;
    else if (op == OP_LDI)                          c = CLS_LDI;
    else if (op == OP_ST)                           c = CLS_ST;
    else if (op >= OP_ALU_R_LO && op <= OP_ALU_R_HI) c = CLS_ALU_R;
    else if (op >= OP_ADDI && op <= OP_ORI)         c = CLS_ALU_I;
    else if (op == OP_MUL || op == OP_DIV)          c = CLS_MULDIV;
    else if (op == OP_NEG || op == OP_NOT)          c = CLS_UNARY;
    else if (op == OP_BRX)                          c = CLS_BR;
    else if (op == OP_JR)                           c = CLS_JR;
    else if (op == OP_JAL)                          c = CLS_JAL;
    else if (op == OP_IN)                           c = CLS_IN;
    else if (op == OP_OUT)                          c = CLS_OUT;
    else if (op == OP_MFHI)                         c = CLS_MFHI;
    else if (op == OP_MFLO)                         c = CLS_MFLO;
    else if (op == OP_HALT)                         c = CLS_HALT;
    else                                            c = CLS_NOP;
    return c;
  endfunction

  // Final execute state of each class: the instruction boundary.
  function automatic logic [3:0] last_state(input cls_t c);
    logic [3:0] s;
    case (c)
      CLS_ALU_R, CLS_ALU_I, CLS_LDI: s = S_T5;
      CLS_UNARY, CLS_JAL:            s = S_T4;
      CLS_MULDIV, CLS_BR:            s = S_T6;
      CLS_LD, CLS_ST:                s = S_T7;
      default:                       s = S_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the CPU datapath.
// Fetch runs T0..T2, then a class-specific execute sequence in T3..T7.
// Ports:
//   clock, clear         : rising-edge clock, async active-high reset
//   ir, con_ff           : instruction register, branch condition flag
//   mem_ready            : memory has completed the current Read/Write
//   stop                 : halt request, sampled only at instruction boundary
//   *out / *in / gr*     : bus drive enables, register loads, field selects
//   Read, Write, alu_op  : memory strobes and ALU operation
//   run                  : high in T0..T7
//   dbg_state            : current sequencer state
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout, MDRout, RZLOout, RZHIout, HIout, LOout,
  output logic        PORTout, Cout, BAout, rout,
  output logic        PCin, IncPC, MARin, MDRin, IRin, RYin, RZin,
  output logic        HIin, LOin, PORTin, CONin, rin,
  output logic        gra, grb, grc,
  output logic        Read, Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  dbg_state
);

  logic [3:0]     state, nxt;
  logic [OPW-1:0] opcode;
  cls_t           cls;
  logic           mem_wait;
  logic           unused_ir;

  assign opcode    = ir[31:32-OPW];
  assign unused_ir = ^ir[31-OPW:0];
  assign cls       = decode_class(opcode);
  assign dbg_state = state;

  // States whose memory access must complete before moving on.
  assign mem_wait = !mem_ready &&
                    ((state == S_T1) ||
                     (state == S_T6 && cls == CLS_LD) ||
                     (state == S_T7 && cls == CLS_ST));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_RST;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (state == S_RST) begin
      nxt = S_T0;
    end else if (state == S_HALT) begin
      nxt = S_HALT;
    end else if (mem_wait) begin
      nxt = state;
    end else if (state == S_T3 && cls == CLS_HALT) begin
      nxt = S_HALT;
    end else if (state >= S_T3 && state == last_state(cls)) begin
      nxt = stop ? S_HALT : S_T0;
    end else if (state >= S_T0 && state < S_T7) begin
      nxt = state + 4'd1;
    end else begin
      nxt = S_RST;
    end
  end

  assign run = (state >= S_T0) && (state <= S_T7);

  // Output decode; every signal defaults low so RST and HALT drive nothing.
  always_comb begin
    PCout = 1'b0; MDRout = 1'b0; RZLOout = 1'b0; RZHIout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; PORTout = 1'b0; Cout = 1'b0;
    BAout = 1'b0; rout = 1'b0;
    PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    RYin = 1'b0; RZin = 1'b0; HIin = 1'b0; LOin = 1'b0; PORTin = 1'b0;
    CONin = 1'b0; rin = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu_op = 5'd0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1; end
      S_T1: begin RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: begin grb = 1'b1; rout = 1'b1; RYin = 1'b1; end
          CLS_UNARY:  begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; alu_op = opcode; end
          CLS_MULDIV: begin gra = 1'b1; rout = 1'b1; RYin = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
          CLS_BR:     begin gra = 1'b1; rout = 1'b1; CONin = 1'b1; end
          CLS_JR:     begin gra = 1'b1; rout = 1'b1; PCin = 1'b1; end
          CLS_JAL:    begin PCout = 1'b1; grb = 1'b1; rin = 1'b1; end
          CLS_IN:     begin PORTout = 1'b1; gra = 1'b1; rin = 1'b1; end
          CLS_OUT:    begin gra = 1'b1; rout = 1'b1; PORTin = 1'b1; end
          CLS_MFHI:   begin HIout = 1'b1; gra = 1'b1; rin = 1'b1; end
          CLS_MFLO:   begin LOout = 1'b1; gra = 1'b1; rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CLS_ALU_R:  begin grc = 1'b1; rout = 1'b1; RZin = 1'b1; alu_op = opcode; end
          CLS_ALU_I:  begin Cout = 1'b1; RZin = 1'b1; alu_op = opcode; end
          CLS_UNARY:  begin RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; end
          CLS_MULDIV: begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; alu_op = opcode; end
          CLS_LD, CLS_LDI, CLS_ST: begin Cout = 1'b1; RZin = 1'b1; alu_op = ADD_OP; end
          CLS_BR:     begin PCout = 1'b1; RYin = 1'b1; end
          CLS_JAL:    begin gra = 1'b1; rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; end
          CLS_MULDIV: begin RZLOout = 1'b1; LOin = 1'b1; end
          CLS_LD, CLS_ST: begin RZLOout = 1'b1; MARin = 1'b1; end
          CLS_BR:     begin Cout = 1'b1; RZin = 1'b1; alu_op = ADD_OP; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CLS_MULDIV: begin RZHIout = 1'b1; HIin = 1'b1; end
          CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          CLS_ST:     begin gra = 1'b1; rout = 1'b1; MDRin = 1'b1; end
          CLS_BR:     begin RZLOout = 1'b1; PCin = con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          CLS_LD: begin MDRout = 1'b1; gra = 1'b1; rin = 1'b1; end
          CLS_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a table of per-cycle expected states/controls for
// whole instructions, then scripted sequences for memory waits, reset abort,
// stop handling and halt.
module tb_control_unit;
  import cpu_pkg::*;

  logic        clock, clear, con_ff, mem_ready, stop;
  logic [31:0] ir;
  logic PCout, MDRout, RZLOout, RZHIout, HIout, LOout, PORTout, Cout, BAout, rout;
  logic PCin, IncPC, MARin, MDRin, IRin, RYin, RZin, HIin, LOin, PORTin, CONin, rin;
  logic gra, grb, grc, Read, Write, run;
  logic [4:0] alu_op;
  logic [3:0] dbg_state;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
    .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .MDRout(MDRout), .RZLOout(RZLOout), .RZHIout(RZHIout),
    .HIout(HIout), .LOout(LOout), .PORTout(PORTout), .Cout(Cout),
    .BAout(BAout), .rout(rout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .RYin(RYin), .RZin(RZin), .HIin(HIin), .LOin(LOin), .PORTin(PORTin),
    .CONin(CONin), .rin(rin),
    .gra(gra), .grb(grb), .grc(grc), .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run), .dbg_state(dbg_state)
  );

  // Control bit positions in the bench's packed view of the outputs
  localparam logic [27:0] C_PCOUT = 28'd1 << 0,  C_MDROUT = 28'd1 << 1,
                          C_RZLO  = 28'd1 << 2,  C_RZHI   = 28'd1 << 3,
                          C_HIOUT = 28'd1 << 4,  C_LOOUT  = 28'd1 << 5,
                          C_PORTOUT = 28'd1 << 6, C_COUT  = 28'd1 << 7,
                          C_BAOUT = 28'd1 << 8,  C_ROUT   = 28'd1 << 9,
                          C_PCIN  = 28'd1 << 10, C_INCPC  = 28'd1 << 11,
                          C_MARIN = 28'd1 << 12, C_MDRIN  = 28'd1 << 13,
                          C_IRIN  = 28'd1 << 14, C_RYIN   = 28'd1 << 15,
                          C_RZIN  = 28'd1 << 16, C_HIIN   = 28'd1 << 17,
                          C_LOIN  = 28'd1 << 18, C_PORTIN = 28'd1 << 19,
                          C_CONIN = 28'd1 << 20, C_RIN    = 28'd1 << 21,
                          C_GRA   = 28'd1 << 22, C_GRB    = 28'd1 << 23,
                          C_GRC   = 28'd1 << 24, C_READ   = 28'd1 << 25,
                          C_WRITE = 28'd1 << 26, C_RUN    = 28'd1 << 27;

  localparam logic [27:0] FETCH0 = C_PCOUT | C_MARIN | C_INCPC | C_RZIN;
  localparam logic [27:0] FETCH1 = C_RZLO | C_PCIN | C_READ | C_MDRIN;
  localparam logic [27:0] FETCH2 = C_MDROUT | C_IRIN;

  logic [27:0] act_ctl;
  assign act_ctl = {run, Write, Read, grc, grb, gra, rin, CONin, PORTin, LOin,
                    HIin, RZin, RYin, IRin, MDRin, MARin, IncPC, PCin, rout,
                    BAout, Cout, PORTout, LOout, HIout, RZHIout, RZLOout,
                    MDRout, PCout};

  typedef struct {
    logic [31:0] ir;
    logic        cf;
    logic [3:0]  st;
    logic [27:0] ctl;
    logic [4:0]  alu;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 27'd0};
  endfunction

  // Rows describe T-states, so run is always expected high.
  task automatic push(input logic [31:0] i, input logic cf, input logic [3:0] st,
                      input logic [27:0] ctl, input logic [4:0] alu);
    vec_t v;
    v.ir = i; v.cf = cf; v.st = st; v.ctl = ctl | C_RUN; v.alu = alu;
    vecs.push_back(v);
  endtask

  task automatic push_fetch(input logic [31:0] i, input logic cf);
    push(i, cf, S_T0, FETCH0, 5'd0);
    push(i, cf, S_T1, FETCH1, 5'd0);
    push(i, cf, S_T2, FETCH2, 5'd0);
  endtask

  task automatic build_table();
    logic [31:0] i;
    // add
    i = 32'h18910000; push_fetch(i, 0);
    push(i, 0, S_T3, C_GRB | C_ROUT | C_RYIN, 0);
    push(i, 0, S_T4, C_GRC | C_ROUT | C_RZIN, 5'b00011);
    push(i, 0, S_T5, C_RZLO | C_GRA | C_RIN, 0);
    // last R-type opcode
    i = mk(5'b01011); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRB | C_ROUT | C_RYIN, 0);
    push(i, 0, S_T4, C_GRC | C_ROUT | C_RZIN, 5'b01011);
    push(i, 0, S_T5, C_RZLO | C_GRA | C_RIN, 0);
    // addi and ori
    i = mk(5'b01100); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRB | C_ROUT | C_RYIN, 0);
    push(i, 0, S_T4, C_COUT | C_RZIN, 5'b01100);
    push(i, 0, S_T5, C_RZLO | C_GRA | C_RIN, 0);
    i = mk(5'b01110); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRB | C_ROUT | C_RYIN, 0);
    push(i, 0, S_T4, C_COUT | C_RZIN, 5'b01110);
    push(i, 0, S_T5, C_RZLO | C_GRA | C_RIN, 0);
    // neg
    i = mk(5'b10001); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRB | C_ROUT | C_RZIN, 5'b10001);
    push(i, 0, S_T4, C_RZLO | C_GRA | C_RIN, 0);
    // mul: 7 cycles
    i = mk(5'b01111); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRA | C_ROUT | C_RYIN, 0);
    push(i, 0, S_T4, C_GRB | C_ROUT | C_RZIN, 5'b01111);
    push(i, 0, S_T5, C_RZLO | C_LOIN, 0);
    push(i, 0, S_T6, C_RZHI | C_HIIN, 0);
    // ldi
    i = mk(5'b00001); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRB | C_BAOUT | C_RYIN, 0);
    push(i, 0, S_T4, C_COUT | C_RZIN, 5'b00011);
    push(i, 0, S_T5, C_RZLO | C_GRA | C_RIN, 0);
    // brx not taken, then taken
    i = mk(5'b10011); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRA | C_ROUT | C_CONIN, 0);
    push(i, 0, S_T4, C_PCOUT | C_RYIN, 0);
    push(i, 0, S_T5, C_COUT | C_RZIN, 5'b00011);
    push(i, 0, S_T6, C_RZLO, 0);
    push_fetch(i, 1);
    push(i, 1, S_T3, C_GRA | C_ROUT | C_CONIN, 0);
    push(i, 1, S_T4, C_PCOUT | C_RYIN, 0);
    push(i, 1, S_T5, C_COUT | C_RZIN, 5'b00011);
    push(i, 1, S_T6, C_RZLO | C_PCIN, 0);
    // jr, jal
    i = mk(5'b10100); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRA | C_ROUT | C_PCIN, 0);
    i = mk(5'b10101); push_fetch(i, 0);
    push(i, 0, S_T3, C_PCOUT | C_GRB | C_RIN, 0);
    push(i, 0, S_T4, C_GRA | C_ROUT | C_PCIN, 0);
    // in, out, mfhi, mflo
    i = mk(5'b10110); push_fetch(i, 0);
    push(i, 0, S_T3, C_PORTOUT | C_GRA | C_RIN, 0);
    i = mk(5'b10111); push_fetch(i, 0);
    push(i, 0, S_T3, C_GRA | C_ROUT | C_PORTIN, 0);
    i = mk(5'b11000); push_fetch(i, 0);
    push(i, 0, S_T3, C_HIOUT | C_GRA | C_RIN, 0);
    i = mk(5'b11001); push_fetch(i, 0);
    push(i, 0, S_T3, C_LOOUT | C_GRA | C_RIN, 0);
    // nop and an undefined opcode: empty T3
    i = mk(5'b11010); push_fetch(i, 0);
    push(i, 0, S_T3, 28'd0, 0);
    i = mk(5'b11111); push_fetch(i, 0);
    push(i, 0, S_T3, 28'd0, 0);
  endtask

  initial begin
    int cyc, rd_run, rd_max;
    int waits;
    clear = 1'b1; ir = 32'd0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0;
    build_table();

    // Reset state
    tick();
    chk("reset state", {28'd0, dbg_state}, {28'd0, S_RST});
    chk("reset ctl", {4'd0, act_ctl}, 32'd0);
    chk("reset alu", {27'd0, alu_op}, 32'd0);
    clear = 1'b0;
    sample();
    chk("rst held state", {28'd0, dbg_state}, {28'd0, S_RST});
    tick();

    // Table: consecutive instructions, each row one cycle
    foreach (vecs[k]) begin
      ir = vecs[k].ir; con_ff = vecs[k].cf;
      sample();
      chk($sformatf("vec%0d state", k), {28'd0, dbg_state}, {28'd0, vecs[k].st});
      chk($sformatf("vec%0d ctl", k), {4'd0, act_ctl}, {4'd0, vecs[k].ctl});
      chk($sformatf("vec%0d alu", k), {27'd0, alu_op}, {27'd0, vecs[k].alu});
      tick();
    end
    con_ff = 1'b0;

    // ld with 3 wait cycles in T6: 11 cycles, Read high 4 in a row
    ir = mk(5'b00000);
    cyc = 0; rd_run = 0; rd_max = 0; waits = 0;
    do begin
      sample();
      cyc++;
      if (Read) rd_run++; else rd_run = 0;
      if (rd_run > rd_max) rd_max = rd_run;
      if (dbg_state == S_T7)
        chk("ld T7 ctl", {4'd0, act_ctl}, {4'd0, C_RUN | C_MDROUT | C_GRA | C_RIN});
      if (dbg_state == S_T6 && waits < 3) begin
        mem_ready = 1'b0; waits++;
      end else begin
        mem_ready = 1'b1;
      end
      tick();
    end while (dbg_state != S_T0 && cyc < 30);
    chk("ld cycles", cyc, 11);
    chk("ld read run", rd_max, 4);

    // st: T1 wait, T7 Write held, then clear aborts mid-cycle
    ir = mk(5'b00010);
    sample(); chk("st T0", {28'd0, dbg_state}, {28'd0, S_T0});
    mem_ready = 1'b0;
    tick(); tick();
    sample(); chk("T1 hold state", {28'd0, dbg_state}, {28'd0, S_T1});
    chk("T1 hold ctl", {4'd0, act_ctl}, {4'd0, C_RUN | FETCH1});
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    sample(); chk("st T6 ctl", {4'd0, act_ctl}, {4'd0, C_RUN | C_GRA | C_ROUT | C_MDRIN});
    mem_ready = 1'b0;
    tick();
    sample(); chk("st T7 write", {4'd0, act_ctl}, {4'd0, C_RUN | C_WRITE});
    tick();
    sample(); chk("st T7 held", {4'd0, act_ctl}, {4'd0, C_RUN | C_WRITE});
    #1 clear = 1'b1;
    #1;
    chk("abort ctl", {4'd0, act_ctl}, 32'd0);
    chk("abort state", {28'd0, dbg_state}, {28'd0, S_RST});
    #1 clear = 1'b0; mem_ready = 1'b1;
    tick();
    sample();
    chk("post-reset T0", {28'd0, dbg_state}, {28'd0, S_T0});
    chk("post-reset ctl", {4'd0, act_ctl}, {4'd0, C_RUN | FETCH0});

    // stop raised in T4 of add: T5 still runs, then HALT
    ir = 32'h18910000;
    tick(); tick(); tick(); tick();
    sample(); chk("add T4", {28'd0, dbg_state}, {28'd0, S_T4});
    stop = 1'b1;
    tick();
    sample(); chk("stop T5", {28'd0, dbg_state}, {28'd0, S_T5});
    chk("stop T5 ctl", {4'd0, act_ctl}, {4'd0, C_RUN | C_RZLO | C_GRA | C_RIN});
    tick();
    sample(); chk("halted", {28'd0, dbg_state}, {28'd0, S_HALT});
    chk("halt run", {31'd0, run}, 32'd0);
    stop = 1'b0;
    tick(); tick(); tick();
    sample(); chk("halt absorbing", {28'd0, dbg_state}, {28'd0, S_HALT});
    chk("halt ctl", {4'd0, act_ctl}, 32'd0);
    #1 clear = 1'b1;
    #1 clear = 1'b0;
    tick();
    sample(); chk("halt exit T0", {28'd0, dbg_state}, {28'd0, S_T0});

    // halt opcode
    ir = mk(5'b11011);
    tick(); tick(); tick();
    sample(); chk("halt op T3", {28'd0, dbg_state}, {28'd0, S_T3});
    chk("halt op T3 ctl", {4'd0, act_ctl}, {4'd0, C_RUN});
    tick();
    sample(); chk("halt op HALT", {28'd0, dbg_state}, {28'd0, S_HALT});
    tick(); tick();
    sample(); chk("halt op stays", {28'd0, dbg_state}, {28'd0, S_HALT});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
